// File: rtl/fp_convert_ctrl.sv
// Multi-cycle 12-bit two's-complement to 8-bit float (sign, 3-bit exponent, 4-bit significand)
// converter: one serial normalization shift per cycle, round-to-nearest on the fifth bit.
module fp_convert_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] d,
  output logic        s,
  output logic [2:0]  e,
  output logic [3:0]  f,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE,
    ABS,
    NORM,
    ROUND,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [11:0] d_reg;
  logic [10:0] mag;
  logic [2:0]  exp_cnt;

  logic [11:0] d_neg;
  logic [10:0] mag_abs;
  logic        norm_stop;
  logic [3:0]  sig;
  logic        fifth;
  logic [4:0]  sig_inc;
  logic [3:0]  f_rnd;
  logic [2:0]  e_rnd;

  // -2048 has no positive 12-bit counterpart, so its magnitude clamps to 2047.
  always_comb begin
    d_neg   = -d_reg;
    mag_abs = d_reg[10:0];
    if (d_reg[11]) begin
      mag_abs = (d_reg == 12'h800) ? 11'h7FF : d_neg[10:0];
    end
  end

  assign norm_stop = mag[10] || (exp_cnt == 3'd0);

  always_comb begin
    sig     = mag[10:7];
    fifth   = mag[6];
    sig_inc = {1'b0, sig} + 5'd1;
    f_rnd   = sig;
    e_rnd   = exp_cnt;
    if (fifth) begin
      if (!sig_inc[4]) begin
        f_rnd = sig_inc[3:0];
      end else if (exp_cnt != 3'd7) begin
        f_rnd = 4'b1000;
        e_rnd = exp_cnt + 3'd1;
      end else begin
        f_rnd = 4'b1111;
        e_rnd = 3'd7;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ABS;
      ABS:     state_nxt = NORM;
      NORM:    if (norm_stop) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers only change in ROUND, so s/e/f hold between conversions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_reg   <= 12'd0;
      mag     <= 11'd0;
      exp_cnt <= 3'd0;
      s       <= 1'b0;
      e       <= 3'd0;
      f       <= 4'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d_reg <= d;
            busy  <= 1'b1;
          end
        end
        ABS: begin
          mag     <= mag_abs;
          exp_cnt <= 3'd7;
        end
        NORM: begin
          if (!norm_stop) begin
            mag     <= {mag[9:0], 1'b0};
            exp_cnt <= exp_cnt - 3'd1;
          end
        end
        ROUND: begin
          s    <= d_reg[11];
          e    <= e_rnd;
          f    <= f_rnd;
          done <= 1'b1;
          busy <= 1'b0;
        end
        DONE: begin
          done <= 1'b0;
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// Self-checking bench for fp_convert_ctrl: directed test-plan vectors, handshake corner cases,
// mid-conversion reset, and random samples checked against an arithmetic reference model.
module tb_fp_convert_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] d;
  logic        s;
  logic [2:0]  e;
  logic [3:0]  f;
  logic        busy;
  logic        done;

  int checks;
  int errors;

  fp_convert_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .d     (d),
    .s     (s),
    .e     (e),
    .f     (f),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Reference: value = F*2^E with E chosen so F holds the top four magnitude bits,
  // the next bit rounds, and latency is ten cycles minus the pre-round exponent.
  task automatic referenceModel(input logic [11:0] v, output int rs, output int re,
                                output int rf, output int rlat);
    int val;
    int mag;
    int p;
    int ep;
    int fv;
    int fifth;
    val = int'($signed(v));
    mag = (val < 0) ? -val : val;
    if (mag > 2047) mag = 2047;
    p = -1;
    for (int i = 0; i <= 10; i++) begin
      if (mag >= (1 << i)) p = i;
    end
    ep    = (p >= 3) ? p - 3 : 0;
    rlat  = 10 - ep;
    fv    = mag >> ep;
    fifth = (ep > 0) ? ((mag >> (ep - 1)) & 1) : 0;
    if (fifth == 1) begin
      fv++;
      if (fv == 16) begin
        if (ep < 7) begin
          fv = 8;
          ep++;
        end else begin
          fv = 15;
        end
      end
    end
    rs = (val < 0) ? 1 : 0;
    re = ep;
    rf = fv;
  endtask

  // Runs one conversion from IDLE; d is scrambled after accept to expose re-capture.
  task automatic applyStimulus(input string tag, input logic [11:0] v,
                               output int lat, output int busy_cycles);
    start = 1'b1;
    d     = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    d     = 12'($urandom);
    busy_cycles = busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cycles++;
    end
    if (lat < 0) begin
      checkOutput({tag, "_timeout"}, lat, 0);
    end else begin
      checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_width"}, int'(done), 0);
    end
  endtask

  task automatic runConversion(input string tag, input logic [11:0] v, input int es,
                               input int ee, input int ef, input int elat);
    int lat;
    int bc;
    applyStimulus(tag, v, lat, bc);
    checkOutput({tag, "_latency"}, lat, elat);
    checkOutput({tag, "_busy_cycles"}, bc, elat);
    checkOutput({tag, "_s"}, int'(s), es);
    checkOutput({tag, "_e"}, int'(e), ee);
    checkOutput({tag, "_f"}, int'(f), ef);
  endtask

  initial begin
    int rs;
    int re;
    int rf;
    int rlat;
    int k1;
    int k2;
    int done_seen;
    logic [11:0] rv;

    checks = 0;
    errors = 0;
    rst    = 1'b1;
    start  = 1'b0;
    d      = 12'd0;

    #1;
    checkOutput("reset_s", int'(s), 0);
    checkOutput("reset_e", int'(e), 0);
    checkOutput("reset_f", int'(f), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    runConversion("d422", 12'd422, 0, 5, 13, 5);
    runConversion("d46", 12'd46, 0, 2, 12, 8);
    runConversion("dneg46", 12'hFD2, 1, 2, 12, 8);
    runConversion("d62_ovf", 12'd62, 0, 3, 8, 8);
    runConversion("d7ff_sat", 12'h7FF, 0, 7, 15, 3);
    runConversion("d800_clamp", 12'h800, 1, 7, 15, 3);
    runConversion("d0_zero", 12'd0, 0, 0, 0, 10);

    // Back-to-back: start held high, d changes to 46 while the first sample is busy.
    start = 1'b1;
    d     = 12'd422;
    @(posedge clk);
    #1;
    d  = 12'd46;
    k1 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k1 = k;
        break;
      end
    end
    checkOutput("b2b_first_latency", k1, 5);
    checkOutput("b2b_first_e", int'(e), 5);
    checkOutput("b2b_first_f", int'(f), 13);
    @(posedge clk);
    #1;
    checkOutput("b2b_done_width1", int'(done), 0);
    checkOutput("b2b_idle_gap_busy", int'(busy), 0);
    @(posedge clk);
    #1;
    checkOutput("b2b_second_accept", int'(busy), 1);
    start = 1'b0;
    k2 = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        k2 = k;
        break;
      end
    end
    checkOutput("b2b_second_latency", k2, 8);
    checkOutput("b2b_second_s", int'(s), 0);
    checkOutput("b2b_second_e", int'(e), 2);
    checkOutput("b2b_second_f", int'(f), 12);
    @(posedge clk);
    #1;
    checkOutput("b2b_done_width2", int'(done), 0);

    // Reset in the middle of normalizing 5 must abort it without a done.
    start = 1'b1;
    d     = 12'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    checkOutput("abort_s", int'(s), 0);
    checkOutput("abort_e", int'(e), 0);
    checkOutput("abort_f", int'(f), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    done_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);
    runConversion("d5_after_reset", 12'd5, 0, 0, 5, 10);

    // Random samples against the reference model, with the corner values mixed in.
    for (int i = 0; i < 40; i++) begin
      case (i % 8)
        0:       rv = 12'h800;
        1:       rv = 12'($urandom_range(0, 15));
        default: rv = 12'($urandom_range(0, 4095));
      endcase
      referenceModel(rv, rs, re, rf, rlat);
      runConversion($sformatf("rand%0d_%03h", i, rv), rv, rs, re, rf, rlat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_convert_ctrl.md
# fp_convert_ctrl

Multi-cycle sequencer for the 12-bit two's-complement to 8-bit floating-point conversion (sign, 3-bit exponent E, 4-bit significand F; value = F·2^E). The block accepts one sample per start handshake, forms sign/magnitude, normalizes serially by one shift per cycle, applies round-to-nearest on the fifth bit with overflow and saturation handling, and presents a registered result with a one-cycle done pulse. It replaces the combinational conversion chain wherever registered, handshaked results are needed.

## Interface
- No parameters; widths are fixed by the 12-bit-in / 8-bit-out format.
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- d  input  12  two's-complement sample; captured on the accepted start edge.
- s  output  1  sign of the result.
- e  output  3  result exponent.
- f  output  4  result significand.
- busy  output  1  high from the accept edge until the done edge.
- done  output  1  single-cycle pulse; s/e/f are valid from this cycle onward.

## Operation
- FSM states: IDLE, ABS, NORM, ROUND, DONE.
- IDLE: when start=1, capture d, set busy, and go to ABS. Otherwise stay in IDLE.
- ABS: sign = d[11].
  - Magnitude (11-bit) = |d|.
  - d = 12'h800 (-2048) clamps the magnitude to 2047 (11'h7FF).
  - Load the exponent counter with 7, then go to NORM.
- NORM (one decision per cycle):
  - If mag[10]=1 or exp=0, go to ROUND.
  - Otherwise mag <<= 1 (zero fill) and exp -= 1.
- ROUND: take sig = mag[10:7] and fifth = mag[6].
  - fifth=0: F = sig, E = exp.
  - fifth=1 and sig≠1111: F = sig+1, E = exp.
  - fifth=1, sig=1111, exp<7: F = 1000, E = exp+1.
  - fifth=1, sig=1111, exp=7: saturate to F = 1111, E = 7.
- ROUND registers s/e/f, pulses done, clears busy, and goes to DONE.
- DONE: done returns low and the FSM returns to IDLE. DONE lasts one cycle, and start is ignored in it.
- E=0 results come from 7 shifts; mag[6] is then a shifted-in 0, so no rounding occurs.
- start while busy=1 (or in DONE) is ignored; d is not re-captured.
- s/e/f hold their last result until the next ROUND writes them.

## Timing
- Reset values (asynchronous): state=IDLE, s=0, e=0, f=0, busy=0, done=0, and internal mag/exp=0.
- Reset asserted mid-conversion aborts it: outputs go to reset values immediately, and no done is produced for the aborted sample.
- Let N = number of NORM shifts (0..7), where N = 7 − E_pre-round.
- Edge sequence, counting edge 0 as the accepting edge:
  - edge 0 → ABS
  - edge 1 → NORM
  - edges 2..N+1 → shifts
  - edge N+2 → ROUND
  - edge N+3 → s/e/f and done registered
- Latency is therefore 3 cycles minimum and 10 maximum.
- done is high for exactly one cycle.
- Earliest next accept is the edge after done falls, i.e. edge N+5 if start is held high.
- busy rises after edge 0 and falls after edge N+3.

## Test plan
- d=12'd422 → s=0, E=5, F=1101 (fifth=0, no round); done 5 cycles after accept, busy high for exactly 5 cycles.
- d=12'd46 → s=0, E=2, F=1100 (round up). Then d=12'hFD2 (−46) → s=1, E=2, F=1100.
- d=12'd62 → significand overflow → s=0, E=3, F=1000. Then d=12'h7FF → saturation → s=0, E=7, F=1111, latency 3.
- d=12'h800 → s=1, E=7, F=1111. Then d=12'd0 → s=0, E=0, F=0000, latency 10.
- Back-to-back start held high with samples 12'd422 then 12'd46:
  - the second sample is not captured while busy;
  - the second accept occurs 2 cycles after the first done;
  - each done is one cycle wide.
- Assert rst during NORM of d=12'd5:
  - outputs go to 0 asynchronously and no done appears;
  - after release, start with 12'd5 → s=0, E=0, F=0101 after 10 cycles.
